sum_window_acc: RTL
===================

Name: sum_window_acc

Overview:
- Downstream consumer of the 2-bit registered adder stage.
- Sums WIN_LEN consecutive accepted 2-bit samples into one ACC_W-bit window total.
- Presents the total on a valid/ready output and blocks further input until the total is taken.
- Sits between the adder register and any width-reducing or reporting logic.

Parameters:
- WIN_LEN, 16, number of samples per window; legal range 1..255.
- ACC_W, 8, accumulator and result width in bits; must be ≥ 2.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear; discards the partial window and any held result.
- in_vld  input  1  input sample valid.
- in_data  input  2  unsigned sample from the adder stage, value 0..3.
- in_rdy  output  1  input ready; a sample transfers when in_vld && in_rdy.
- out_vld  output  1  window total valid.
- out_data  output  ACC_W  window total.
- out_rdy  input  1  output ready; the total transfers when out_vld && out_rdy.
- busy  output  1  high when the partial-window sample count is non-zero.

Behaviour:
- Reset: rst asserted → state=ACCUM, acc=0, cnt=0, out_vld=0, out_data=0, busy=0, in_rdy=0 while rst is high. All effects are immediate (asynchronous reset).
- States: ACCUM and HOLD.
- ACCUM:
  - in_rdy=1.
  - On an accepted sample: next = acc + zero-extended in_data, cnt+1.
  - If cnt+1 == WIN_LEN: out_data <= next, out_vld <= 1, acc <= 0, cnt <= 0, go to HOLD.
  - Otherwise: acc <= next, cnt <= cnt+1.
- HOLD:
  - out_vld=1; out_data stays stable until transferred.
  - in_rdy = out_rdy, combinational, so drain and the next input can occur in the same cycle.
  - out_rdy=1 with no input: out_vld <= 0, go to ACCUM.
  - out_rdy=1 with in_vld=1: the sample is the first of the next window, so acc <= in_data and cnt <= 1.
    - If WIN_LEN==1: stay in HOLD with out_data <= in_data, out_vld held at 1.
  - out_rdy=0: nothing changes and no input is accepted.
- Latency: the result is registered. out_vld rises on the cycle after the WIN_LEN-th sample is accepted.
- Width/arithmetic:
  - Unsigned addition.
  - cnt width is $clog2(WIN_LEN+1).
  - Without the optional feature, overflow wraps modulo 2^ACC_W.
- clr:
  - When clr=1 (synchronous): acc=0, cnt=0, out_vld=0, state=ACCUM.
  - Any input handshake in that cycle is ignored.
  - clr has priority over all simultaneous events, including a completing sample and a drain.
- Boundaries:
  - in_vld with in_rdy=0: the sample is not consumed; the upstream holds it.
  - out_rdy asserted in ACCUM: no effect.
  - rst mid-window or during HOLD: the partial sum and the held result are lost.
- busy = (cnt != 0).

Optional Feature:
- Macro: SUM_WINDOW_ACC_SAT_EN.
- Defined:
  - Each add saturates at 2^ACC_W-1.
  - An extra output `sat` (1 bit) is qualified by out_vld and is high if saturation occurred anywhere within the held window.
  - `sat` is cleared by rst, clr, or the start of a new window.
- Undefined: modulo wrap on overflow; the `sat` port does not exist.

Decomposition:
- Package sum_window_pkg:
  - SAMPLE_W=2.
  - State enum {ACCUM, HOLD}.
  - Default WIN_LEN and ACC_W constants shared with the adder-stage top level.
- Sub-module sum_window_add:
  - Combinational ACC_W + SAMPLE_W adder.
  - Produces the wrap or saturate result, plus a saturation flag under the macro.
- The FSM, counter, and register stay in sum_window_acc.

Test Plan:
- Reset/idle: rst pulse mid-cycle → out_vld=0, out_data=0, busy=0 immediately; in_rdy=1 on the first cycle after release.
- Basic window: WIN_LEN=4, out_rdy=1, samples 3,2,1,3 back-to-back → out_vld=1 with out_data=9 one cycle after the 4th sample, dropping after 1 cycle.
- Backpressure: WIN_LEN=4, all samples=1, out_rdy=0 for 5 cycles after completion → out_data=4 held stable, in_rdy=0 throughout; out_rdy=1 → transfer, and the sample presented that cycle starts the next window (busy=1).
- Overflow: ACC_W=4, WIN_LEN=8, all samples=3 → out_data=8 (24 mod 16). With SUM_WINDOW_ACC_SAT_EN → out_data=15 and sat=1.
- clr priority: WIN_LEN=4, clr asserted together with the 4th sample → no out_vld, cnt=0, busy=0; the next 4 samples of value 2 → out_data=8.
- WIN_LEN=1 streaming: out_rdy=1, samples 1,2,3 continuously → out_vld stays high, out_data = 1,2,3 on consecutive cycles.

Source files
------------

// File: rtl/sum_window_pkg.sv
// sum_window_pkg: shared constants and state type for the window accumulator
// Exports: SAMPLE_W (adder-stage sample width), DEF_WIN_LEN / DEF_ACC_W
// (defaults shared with the adder-stage top level), state_t {ACCUM, HOLD}.
package sum_window_pkg;
  localparam int SAMPLE_W = 2;
  localparam int DEF_WIN_LEN = 16;
  localparam int DEF_ACC_W = 8;
  typedef enum logic {ACCUM, HOLD} state_t;
endpackage

// File: rtl/sum_window_add.sv
// sum_window_add: combinational accumulator + sample adder, wrapping or saturating
// Ports: a (ACC_W running sum), b (SAMPLE_W sample), sum (ACC_W result),
// sat (saturation flag, only with SUM_WINDOW_ACC_SAT_EN defined).
// Macro SUM_WINDOW_ACC_SAT_EN: clamp at 2^ACC_W-1 instead of wrapping.
module sum_window_add
  import sum_window_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]    a,
  input  logic [SAMPLE_W-1:0] b,
  output logic [ACC_W-1:0]    sum
`ifdef SUM_WINDOW_ACC_SAT_EN
  ,
  output logic                sat
`endif
);
`ifdef SUM_WINDOW_ACC_SAT_EN
  logic [ACC_W:0] wide;
  assign wide = {1'b0, a} + (ACC_W+1)'(b);
  assign sat  = wide[ACC_W];
  assign sum  = sat ? '1 : wide[ACC_W-1:0];
`else
  assign sum = a + ACC_W'(b);
`endif
endmodule

// File: rtl/sum_window_acc.sv
// sum_window_acc: sums WIN_LEN accepted 2-bit samples into one registered window total
// Ports: clk, rst (async active-high), clr (sync clear), in_vld/in_rdy/in_data
// (sample input), out_vld/out_rdy/out_data (window total), busy (partial window
// non-empty), sat (window saturated, only with SUM_WINDOW_ACC_SAT_EN defined).
// Macro SUM_WINDOW_ACC_SAT_EN: saturating accumulation plus the sat output.
module sum_window_acc
  import sum_window_pkg::*;
#(
  parameter int WIN_LEN = DEF_WIN_LEN,
  parameter int ACC_W   = DEF_ACC_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                in_vld,
  input  logic [SAMPLE_W-1:0] in_data,
  output logic                in_rdy,
  output logic                out_vld,
  output logic [ACC_W-1:0]    out_data,
  input  logic                out_rdy,
  output logic                busy
`ifdef SUM_WINDOW_ACC_SAT_EN
  ,
  output logic                sat
`endif
);
  localparam int CW = $clog2(WIN_LEN + 1);
  state_t           state;
  logic [ACC_W-1:0] acc, next;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             take, done;
`ifdef SUM_WINDOW_ACC_SAT_EN
  logic             add_sat, win_sat;
`endif
  sum_window_add #(.ACC_W(ACC_W)) u_add (
    .a   (acc),
    .b   (in_data),
    .sum (next)
`ifdef SUM_WINDOW_ACC_SAT_EN
    ,
    .sat (add_sat)
`endif
  );
  // acc and cnt are zero while holding, so a sample taken during a drain
  // naturally becomes the first of the next window.
  assign in_rdy  = !rst && (state == ACCUM || out_rdy);
  assign out_vld = state == HOLD;
  assign busy    = cnt != '0;
  assign take    = in_vld && in_rdy;
  assign cnt_nx  = cnt + 1'b1;
  assign done    = cnt_nx == CW'(WIN_LEN);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACCUM;
      acc      <= '0;
      cnt      <= '0;
      out_data <= '0;
`ifdef SUM_WINDOW_ACC_SAT_EN
      sat      <= 1'b0;
      win_sat  <= 1'b0;
`endif
    end else if (clr) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
`ifdef SUM_WINDOW_ACC_SAT_EN
      sat     <= 1'b0;
      win_sat <= 1'b0;
`endif
    end else if (take && done) begin
      state    <= HOLD;
      out_data <= next;
      acc      <= '0;
      cnt      <= '0;
`ifdef SUM_WINDOW_ACC_SAT_EN
      sat     <= win_sat | add_sat;
      win_sat <= 1'b0;
`endif
    end else if (take) begin
      state <= ACCUM;
      acc   <= next;
      cnt   <= cnt_nx;
`ifdef SUM_WINDOW_ACC_SAT_EN
      sat     <= 1'b0;
      win_sat <= win_sat | add_sat;
`endif
    end else if (out_rdy) begin
      state <= ACCUM;
`ifdef SUM_WINDOW_ACC_SAT_EN
      sat <= 1'b0;
`endif
    end
  end
endmodule
